// File: rtl/rf_pkg.sv
// Shared types and default sizes for the RV32 integer register file.
package rf_pkg;

  localparam int unsigned RF_XLEN  = 32;
  localparam int unsigned RF_NREGS = 32;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

  typedef logic [RF_XLEN-1:0] rf_word_t;

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: walks x1..x(NREGS-1) writing zero, then parks in READY.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = RF_NREGS,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          init_done
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rf_state_e     state, state_nxt;
  logic [AW-1:0] clr_idx, idx_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RF_CLEAR;
      clr_idx <= AW'(1);
    end else begin
      state   <= state_nxt;
      clr_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = clr_idx;
    clr_we    = 1'b0;
    if (state == RF_CLEAR) begin
      clr_we  = 1'b1;
      idx_nxt = clr_idx + AW'(1);
      if (clr_idx == LAST) state_nxt = RF_READY;
    end
  end

  assign clr_addr  = clr_idx;
  assign init_done = (state == RF_READY);

endmodule

// File: rtl/rf_core.sv
// RV32 integer register file: two async read ports, one sync write port,
// unreset storage zeroed by rf_clear_seq after every reset.
module rf_core
  import rf_pkg::*;
#(
  parameter int unsigned XLEN         = RF_XLEN,
  parameter int unsigned NREGS        = RF_NREGS,
  parameter int unsigned AW           = $clog2(NREGS),
  parameter int unsigned WRITE_BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] wd3,
  input  logic            we,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            init_done,
  output logic            wr_drop
);

  localparam bit BYP = (WRITE_BYPASS != 0);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            ext_wr;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] mem [NREGS];

  rf_clear_seq #(.NREGS(NREGS), .AW(AW)) u_clear (
    .clk       (clk),
    .reset     (reset),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done)
  );

  assign ext_wr = we && (A3 != '0);

  // clr_we is high for the whole CLEAR state, so external writes are
  // naturally locked out, including on the CLEAR->READY edge.
  always_comb begin
    wr_en   = ext_wr;
    wr_addr = A3;
    wr_data = wd3;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     wr_drop <= 1'b0;
    else if (!init_done && ext_wr) wr_drop <= 1'b1;
  end

  assign rd1 = (!init_done || A1 == '0) ? '0 :
               (BYP && ext_wr && A3 == A1) ? wd3 : mem[A1];
  assign rd2 = (!init_done || A2 == '0) ? '0 :
               (BYP && ext_wr && A3 == A2) ? wd3 : mem[A2];

endmodule
